writeback_unit: RTL

Parametrised writeback stage for the 5-stage RISC-V pipeline. It owns the MEM/WB pipeline register, with stall, flush and valid tracking. It aligns and sign- or zero-extends load data, selects among four result sources including LUI immediates, and drives the register-file write port. It also keeps a retired-instruction counter for performance monitoring.

---
 rtl/wb_pkg.sv | 18 +
 rtl/writeback_unit_if.sv | 39 +++
 rtl/load_extend.sv | 33 +++
 rtl/writeback_unit.sv | 93 +++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback stage: result-source select and load funct3 codes.
// No logic and no timing of its own.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } result_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_unit_if.sv
// M-stage inputs and W-stage outputs of the writeback stage.
// The pipeline control (master) drives M fields; writeback_unit (slave) drives W fields.
interface writeback_unit_if #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
);

  logic              StallW;
  logic              FlushW;
  logic              ValidM;
  logic              RegWriteM;
  logic [1:0]        ResultSrcM;
  logic [2:0]        LoadFunct3M;
  logic [XLEN-1:0]   ALUResultM;
  logic [XLEN-1:0]   ReadDataM;
  logic [XLEN-1:0]   PCPlus4M;
  logic [XLEN-1:0]   ImmExtM;
  logic [REG_AW-1:0] RdM;

  logic              ValidW;
  logic              RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [XLEN-1:0]   ResultW;
  logic [CNT_W-1:0]  InstretW;

  modport master (
    output StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadFunct3M,
           ALUResultM, ReadDataM, PCPlus4M, ImmExtM, RdM,
    input  ValidW, RegWriteW, RdW, ResultW, InstretW
  );

  modport slave (
    input  StallW, FlushW, ValidM, RegWriteM, ResultSrcM, LoadFunct3M,
           ALUResultM, ReadDataM, PCPlus4M, ImmExtM, RdM,
    output ValidW, RegWriteW, RdW, ResultW, InstretW
  );

endinterface

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension; purely combinational, zero latency.
// No flow control: output follows the inputs.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Halfword select uses only off[1]; a misaligned off[0] is silently ignored.
  assign byte_sel = 8'(word >> {off, 3'b000});
  assign half_sel = 16'(word >> {off[1], 4'b0000});

  always_comb begin
    ext = '0;
    case (funct3)
      F3_LB:   ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  ext = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  ext = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   ext = word;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// MEM/WB register, load extension, result mux, x0-gated write enable and retired counter.
// One cycle M->W latency; StallW holds the register, FlushW (higher priority) loads a bubble.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 64
) (
  input  logic            clk,
  input  logic            rst,
  writeback_unit_if.slave wb
);

  logic              valid_q;
  logic              regwrite_q;
  result_src_e       src_q;
  logic [2:0]        funct3_q;
  logic [XLEN-1:0]   alu_q;
  logic [XLEN-1:0]   rdata_q;
  logic [XLEN-1:0]   pc4_q;
  logic [XLEN-1:0]   imm_q;
  logic [REG_AW-1:0] rd_q;
  logic [CNT_W-1:0]  instret_q;
  logic [XLEN-1:0]   load_ext;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= RES_ALU;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
    end else if (wb.FlushW) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      src_q      <= RES_ALU;
      funct3_q   <= '0;
      alu_q      <= '0;
      rdata_q    <= '0;
      pc4_q      <= '0;
      imm_q      <= '0;
      rd_q       <= '0;
    end else if (!wb.StallW) begin
      valid_q    <= wb.ValidM;
      regwrite_q <= wb.RegWriteM;
      src_q      <= result_src_e'(wb.ResultSrcM);
      funct3_q   <= wb.LoadFunct3M;
      alu_q      <= wb.ALUResultM;
      rdata_q    <= wb.ReadDataM;
      pc4_q      <= wb.PCPlus4M;
      imm_q      <= wb.ImmExtM;
      rd_q       <= wb.RdM;
    end
  end

  // The instruction in W retires on any unstalled edge, even one that flushes the incoming slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instret_q <= '0;
    end else if (valid_q && !wb.StallW) begin
      instret_q <= instret_q + CNT_W'(1);
    end
  end

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .word   (rdata_q),
    .off    (alu_q[1:0]),
    .funct3 (funct3_q),
    .ext    (load_ext)
  );

  always_comb begin
    wb.ResultW = alu_q;
    case (src_q)
      RES_ALU: wb.ResultW = alu_q;
      RES_MEM: wb.ResultW = load_ext;
      RES_PC4: wb.ResultW = pc4_q;
      RES_IMM: wb.ResultW = imm_q;
      default: wb.ResultW = alu_q;
    endcase
  end

  assign wb.ValidW    = valid_q;
  assign wb.RegWriteW = regwrite_q && valid_q && (rd_q != '0);
  assign wb.RdW       = rd_q;
  assign wb.InstretW  = instret_q;

endmodule
